// File: rtl/amo_sequencer.sv
// amo_sequencer: RV32A LR/SC/AMO sequencer driving the data-memory port and holding the LR reservation
module amo_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_funct5,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_src,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_misaligned,
  output logic            resp_illegal,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            inv_valid,
  input  logic [XLEN-1:0] inv_addr
);
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic [4:0]        f5_q, f5_d;
  logic [XLEN-1:2]   addr_q, addr_d, resv_a_q, resv_a_d;
  logic [XLEN-1:0]   src_q, src_d, wdata_q, wdata_d, old_q, old_d, rdata_q, rdata_d;
  logic              resv_v_q, resv_v_d, rv_q, rv_d, mis_q, mis_d, ill_q, ill_d;
  logic              legal, mis, inv_hit, sc_ok, unused_ok;
  logic [XLEN-1:0]   amo_new;
  assign legal   = req_funct5 inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND,
                                      F_MIN, F_MAX, F_MINU, F_MAXU};
  assign mis     = req_addr[1:0] != 2'b00;
  assign inv_hit = inv_valid && inv_addr[XLEN-1:2] == resv_a_q;
  assign sc_ok   = resv_v_q && resv_a_q == req_addr[XLEN-1:2] && !inv_hit;
  assign unused_ok = ^inv_addr[1:0];
  assign amo_new = f5_q == F_SWAP ? src_q :
                   f5_q == F_ADD  ? mem_rdata + src_q :
                   f5_q == F_XOR  ? mem_rdata ^ src_q :
                   f5_q == F_AND  ? mem_rdata & src_q :
                   f5_q == F_MIN  ? ($signed(mem_rdata) < $signed(src_q) ? mem_rdata : src_q) :
                   f5_q == F_MAX  ? ($signed(mem_rdata) > $signed(src_q) ? mem_rdata : src_q) :
                   f5_q == F_MINU ? (mem_rdata < src_q ? mem_rdata : src_q) :
                   f5_q == F_MAXU ? (mem_rdata > src_q ? mem_rdata : src_q) :
                   mem_rdata | src_q;
  assign req_ready       = state_q == IDLE;
  assign mem_valid       = state_q == RD || state_q == WR;
  assign mem_wen         = state_q == WR;
  assign mem_addr        = {addr_q, 2'b00};
  assign mem_wdata       = wdata_q;
  assign resp_valid      = rv_q;
  assign resp_data       = rdata_q;
  assign resp_misaligned = mis_q;
  assign resp_illegal    = ill_q;
  // next-state, operand capture, reservation tracking and response generation
  always_comb begin
    state_d  = state_q;
    f5_d     = f5_q;
    addr_d   = addr_q;
    src_d    = src_q;
    wdata_d  = wdata_q;
    old_d    = old_q;
    resv_v_d = resv_v_q && !inv_hit;
    resv_a_d = resv_a_q;
    rv_d     = 1'b0;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    ill_d    = ill_q;
    case (state_q)
      IDLE: if (req_valid) begin
        f5_d   = req_funct5;
        addr_d = req_addr[XLEN-1:2];
        src_d  = req_src;
        if (mis || !legal) begin
          state_d = RESP;
          rv_d    = 1'b1;
          rdata_d = '0;
          mis_d   = mis;
          ill_d   = !mis;
        end else if (req_funct5 == F_SC) begin
          resv_v_d = 1'b0;
          wdata_d  = req_src;
          state_d  = sc_ok ? WR : RESP;
          rv_d     = !sc_ok;
          rdata_d  = XLEN'(!sc_ok);
          mis_d    = 1'b0;
          ill_d    = 1'b0;
        end else
          state_d = RD;
      end
      RD: if (mem_ready) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid) begin
        if (f5_q == F_LR) begin
          resv_v_d = 1'b1;
          resv_a_d = addr_q;
          state_d  = RESP;
          rv_d     = 1'b1;
          rdata_d  = mem_rdata;
          mis_d    = 1'b0;
          ill_d    = 1'b0;
        end else begin
          old_d   = mem_rdata;
          wdata_d = amo_new;
          state_d = WR;
        end
      end
      WR: if (mem_ready) begin
        state_d = WR_WAIT;
        if (resv_a_q == addr_q) resv_v_d = 1'b0;
      end
      WR_WAIT: if (mem_rvalid) begin
        state_d = RESP;
        rv_d    = 1'b1;
        rdata_d = f5_q == F_SC ? '0 : old_q;
        mis_d   = 1'b0;
        ill_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      f5_q     <= '0;
      addr_q   <= '0;
      src_q    <= '0;
      wdata_q  <= '0;
      old_q    <= '0;
      resv_v_q <= 1'b0;
      resv_a_q <= '0;
      rv_q     <= 1'b0;
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      f5_q     <= f5_d;
      addr_q   <= addr_d;
      src_q    <= src_d;
      wdata_q  <= wdata_d;
      old_q    <= old_d;
      resv_v_q <= resv_v_d;
      resv_a_q <= resv_a_d;
      rv_q     <= rv_d;
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      ill_q    <= ill_d;
    end
  end
endmodule

// File: tb/tb_amo_sequencer.sv
// tb_amo_sequencer: directed self-checking bench for amo_sequencer with a stallable memory responder
module tb_amo_sequencer;
  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;
  localparam logic [4:0] F_BAD  = 5'b11111;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid, req_ready, resp_valid, resp_misaligned, resp_illegal;
  logic [4:0] req_funct5;
  logic [31:0] req_addr, req_src, resp_data, mem_addr, mem_wdata, mem_rdata, inv_addr;
  logic mem_valid, mem_ready, mem_wen, mem_rvalid, inv_valid;
  int errors = 0, checks = 0, cyc = 0;
  int t_acc, lat, rd0, wr0, mv0;
  logic [31:0] rdat;
  logic rmis, rill;
  int rd_cnt = 0, wr_cnt = 0, mv_cnt = 0, unstable = 0, stall_cfg = 0;
  logic [31:0] last_wa = '0, last_wd = '0, rd_val = '0;
  logic hold_rvalid = 1'b0;
  logic [4:0]  t_f5  [10] = '{F_ADD, F_MIN, F_MINU, F_MAX, F_MAXU, F_SWAP, F_XOR, F_AND, F_OR, F_MIN};
  logic [31:0] t_old [10] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                              32'h12345678, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFE};
  logic [31:0] t_src [10] = '{32'h2, 32'h1, 32'h1, 32'h1, 32'h1,
                              32'hCAFEF00D, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h3};
  logic [31:0] t_new [10] = '{32'h1, 32'h80000000, 32'h1, 32'h1, 32'h80000000,
                              32'hCAFEF00D, 32'h0FF00FF0, 32'hF000F000, 32'hFFF0FFF0, 32'hFFFFFFFE};

  amo_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
    .req_addr(req_addr), .req_src(req_src),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inv_valid(inv_valid), .inv_addr(inv_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory responder: optional stall before ready, rvalid one cycle after each handshake
  initial begin
    logic hs, h_wen, stalled;
    logic [31:0] h_addr, h_data;
    logic [64:0] cap;
    int stall;
    stalled = 1'b0;
    stall = 0;
    cap = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      hs = mem_valid && mem_ready && !reset;
      if (mem_valid) mv_cnt++;
      if (stalled && mem_valid && {mem_wen, mem_addr, mem_wdata} !== cap) unstable++;
      stalled = mem_valid && !mem_ready;
      cap = {mem_wen, mem_addr, mem_wdata};
      h_wen = mem_wen;
      h_addr = mem_addr;
      h_data = mem_wdata;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (hs) begin
        stall = 0;
        if (h_wen) begin
          wr_cnt++;
          last_wa = h_addr;
          last_wd = h_data;
        end else begin
          rd_cnt++;
          mem_rdata = rd_val;
        end
        mem_rvalid = !hold_rvalid;
      end
      if (mem_valid && stall < stall_cfg) begin
        mem_ready = 1'b0;
        stall++;
      end else
        mem_ready = mem_valid;
    end
  end

  task automatic start_req(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] s);
    req_valid = 1'b1;
    req_funct5 = f5;
    req_addr = a;
    req_src = s;
    t_acc = cyc;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    mv0 = mv_cnt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    inv_valid = 1'b0;
    check("busy_ready", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic wait_resp();
    lat = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = cyc - t_acc;
        rdat = resp_data;
        rmis = resp_misaligned;
        rill = resp_illegal;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat >= 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] s);
    start_req(f5, a, s);
    wait_resp();
  endtask

  initial begin
    req_valid = 1'b0;
    req_funct5 = '0;
    req_addr = '0;
    req_src = '0;
    inv_valid = 1'b0;
    inv_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", {31'd0, req_ready}, 32'd1);
    rd_val = 32'hDEADBEEF;
    run(F_LR, 32'h100, 32'h0);
    check("lr_lat", 32'(lat), 32'd3);
    check("lr_data", rdat, 32'hDEADBEEF);
    check("lr_reads", 32'(rd_cnt - rd0), 32'd1);
    check("lr_writes", 32'(wr_cnt - wr0), 32'd0);
    run(F_SC, 32'h100, 32'h5);
    check("sc_lat", 32'(lat), 32'd3);
    check("sc_data", rdat, 32'd0);
    check("sc_writes", 32'(wr_cnt - wr0), 32'd1);
    check("sc_reads", 32'(rd_cnt - rd0), 32'd0);
    check("sc_waddr", last_wa, 32'h100);
    check("sc_wdata", last_wd, 32'h5);
    run(F_SC, 32'h100, 32'h9);
    check("sc2_lat", 32'(lat), 32'd1);
    check("sc2_data", rdat, 32'd1);
    check("sc2_mem_valid", 32'(mv_cnt - mv0), 32'd0);
    rd_val = 32'h11112222;
    run(F_LR, 32'h200, 32'h0);
    inv_valid = 1'b1;
    inv_addr = 32'h202;
    run(F_SC, 32'h200, 32'h3);
    check("race_sc_lat", 32'(lat), 32'd1);
    check("race_sc_data", rdat, 32'd1);
    check("race_sc_mem_valid", 32'(mv_cnt - mv0), 32'd0);
    rd_val = 32'h33334444;
    start_req(F_LR, 32'h240, 32'h0);
    @(posedge clk);
    #1;
    inv_valid = 1'b1;
    inv_addr = 32'h240;
    @(posedge clk);
    #1;
    inv_valid = 1'b0;
    wait_resp();
    check("lr_inv_lat", 32'(lat), 32'd3);
    check("lr_inv_data", rdat, 32'h33334444);
    run(F_SC, 32'h240, 32'h7);
    check("lr_inv_sc_data", rdat, 32'd0);
    check("lr_inv_sc_wdata", last_wd, 32'h7);
    for (int i = 0; i < 10; i++) begin
      rd_val = t_old[i];
      run(t_f5[i], 32'h400 + 32'(4 * i), t_src[i]);
      check($sformatf("amo%0d_lat", i), 32'(lat), 32'd5);
      check($sformatf("amo%0d_data", i), rdat, t_old[i]);
      check($sformatf("amo%0d_waddr", i), last_wa, 32'h400 + 32'(4 * i));
      check($sformatf("amo%0d_wdata", i), last_wd, t_new[i]);
    end
    run(F_LR, 32'h500, 32'h0);
    run(F_SWAP, 32'h500, 32'h1);
    run(F_SC, 32'h500, 32'h2);
    check("amo_kill_sc", rdat, 32'd1);
    check("amo_kill_mem_valid", 32'(mv_cnt - mv0), 32'd0);
    run(F_LR, 32'h504, 32'h0);
    run(F_ADD, 32'h508, 32'h1);
    run(F_SC, 32'h504, 32'h2);
    check("amo_other_sc", rdat, 32'd0);
    stall_cfg = 4;
    rd_val = 32'd10;
    run(F_ADD, 32'h600, 32'd5);
    check("bp_lat", 32'(lat), 32'd13);
    check("bp_data", rdat, 32'd10);
    check("bp_reads", 32'(rd_cnt - rd0), 32'd1);
    check("bp_writes", 32'(wr_cnt - wr0), 32'd1);
    check("bp_wdata", last_wd, 32'd15);
    check("bp_waddr", last_wa, 32'h600);
    check("bp_unstable", 32'(unstable), 32'd0);
    stall_cfg = 0;
    run(F_ADD, 32'h103, 32'h1);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_flag", {31'd0, rmis}, 32'd1);
    check("mis_ill", {31'd0, rill}, 32'd0);
    check("mis_data", rdat, 32'd0);
    check("mis_mem_valid", 32'(mv_cnt - mv0), 32'd0);
    run(F_BAD, 32'h100, 32'h1);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_flag", {31'd0, rill}, 32'd1);
    check("ill_mis", {31'd0, rmis}, 32'd0);
    check("ill_mem_valid", 32'(mv_cnt - mv0), 32'd0);
    run(F_BAD, 32'h102, 32'h1);
    check("both_mis", {31'd0, rmis}, 32'd1);
    check("both_ill", {31'd0, rill}, 32'd0);
    run(F_LR, 32'h300, 32'h0);
    hold_rvalid = 1'b1;
    start_req(F_LR, 32'h300, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold_rvalid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    run(F_SC, 32'h300, 32'h4);
    check("post_rst_sc_lat", 32'(lat), 32'd1);
    check("post_rst_sc_data", rdat, 32'd1);
    check("post_rst_sc_mem_valid", 32'(mv_cnt - mv0), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/amo_sequencer.md
# amo_sequencer

Sequencer for RV32A atomics (A_OP, funct3 = A_F3). It accepts one decoded LR.W/SC.W/AMO*.W operation at a time from the execute/memory stage and drives the data-memory port through read, compute and write phases. It holds the single LR reservation and returns the rd value. It sits between the memory stage and the data-memory arbiter, in parallel with the plain load/store path.

## Interface
- XLEN, 32, data/address width (RV32 only)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operation offered
- req_ready  out  1  sequencer can accept (IDLE only)
- req_funct5  in  5  instr[31:27] (A_*_W_F5 encodings)
- req_addr  in  XLEN  rs1 value
- req_src  in  XLEN  rs2 value
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  XLEN  rd write value
- resp_misaligned  out  1  with resp_valid: req_addr[1:0] != 0
- resp_illegal  out  1  with resp_valid: funct5 not a defined A encoding
- mem_valid  out  1  memory request
- mem_ready  in  1  request accepted
- mem_wen  out  1  1 = word write, 0 = word read
- mem_addr  out  XLEN  word-aligned address
- mem_wdata  out  XLEN  store data
- mem_rvalid  in  1  read data or write acknowledge
- mem_rdata  in  XLEN  read data
- inv_valid  in  1  another agent stored to inv_addr
- inv_addr  in  XLEN  invalidation address (word granularity)

## Operation
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP.
- Accept on req_valid && req_ready. Latch funct5, addr, src.
- Misaligned or illegal funct5: IDLE→RESP. No memory access. Flag set, resp_data = 0. Misaligned takes priority over illegal.
- LR.W: RD→RD_WAIT. On mem_rvalid, set reservation {valid=1, addr[31:2]} and go to RESP. resp_data = rdata.
- SC.W: evaluated in the acceptance cycle.
  - Success requires a valid reservation with matching addr[31:2] and no matching inv_valid in that same cycle. IDLE→WR→WR_WAIT→RESP, resp_data = 0.
  - Failure: IDLE→RESP, resp_data = 1, no memory access.
  - The reservation is cleared at acceptance in both cases.
- AMO (SWAP, ADD, XOR, AND, OR, MIN, MAX, MINU, MAXU): RD→RD_WAIT. Capture old = mem_rdata. Then WR with new = f(old, src)→WR_WAIT→RESP. resp_data = old.
  - ADD wraps mod 2^32.
  - MIN/MAX compare as signed 32-bit; MINU/MAXU compare as unsigned.
  - SWAP: new = src.
  - An AMO clears the reservation if it writes the reserved word.
- Reservation invalidation: inv_valid with inv_addr[31:2] matching clears the reservation. If LR's reservation-set and a matching inv_valid occur in the same cycle, the set wins.
- mem_valid, mem_wen, mem_addr, mem_wdata stay stable from the cycle mem_valid rises until the mem_ready handshake cycle inclusive. After the handshake, move to *_WAIT and drop mem_valid.
- mem_rvalid is ignored outside RD_WAIT and WR_WAIT.
- RESP lasts exactly one cycle, then IDLE. There is no response back-pressure.
- Reset (any state, asynchronous): state = IDLE, reservation invalid, all outputs 0 except req_ready, which is 1 after reset deassertion. An in-flight memory transaction is abandoned; the memory arbiter is reset on the same reset.

## Timing
- req_ready = (state == IDLE), combinational from state.
- mem_valid rises the cycle after acceptance (RD/WR entry). A write follows the read by one cycle, entering WR after mem_rvalid.
- Zero-wait memory (mem_ready = 1 at request; mem_rvalid the cycle after the handshake):
  - LR: accept at T, resp at T+3.
  - AMO: accept at T, resp at T+5.
  - Successful SC: accept at T, resp at T+3.
  - Failed SC, misaligned or illegal: accept at T, resp at T+1.
- Minimum spacing between accepts is 2 cycles (RESP, then IDLE).
- resp_* outputs are registered. resp_data, resp_misaligned and resp_illegal hold their last value when resp_valid = 0; only resp_valid is checked.

## Test plan
- LR/SC pair: LR to 0x100, mem returns 0xDEADBEEF, then SC 0x100 with src = 0x5 -> LR resp 0xDEADBEEF at T+3; SC writes 0x5 to 0x100 and returns 0. A second SC to 0x100 returns 1 with no mem_valid.
- Invalidation race: LR 0x200, then inv_valid with inv_addr = 0x202 in the same cycle as SC 0x200 is accepted -> SC returns 1 with no write. Also: inv_valid in the same cycle as the LR's mem_rvalid -> the reservation is still set.
- AMOADD wrap: mem 0xFFFFFFFF, src 0x2 -> writes 0x00000001, resp 0xFFFFFFFF.
- AMOMIN vs AMOMINU: mem 0x80000000, src 0x1 -> MIN writes 0x80000000, MINU writes 0x00000001; both resp 0x80000000.
- Back-pressure: mem_ready low for 4 cycles on both read and write -> request fields stable, exactly one read and one write handshake, resp 4+4 cycles later than the zero-wait case.
- Errors and reset: addr 0x103 -> resp_misaligned, no mem_valid. funct5 = 5'b11111 -> resp_illegal. Reset asserted in RD_WAIT -> IDLE, reservation cleared, a later SC fails.
